// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: LW/LBU/SW/SB against a
// word-organised internal array, with a read-modify-write sequence for SB.
module dmem_responder #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_is_store_i,
  input  logic              req_is_byte_i,
  input  logic [31:0]       req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    RMW,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rmw_idx_q, rmw_idx_d;
  logic [7:0]        rmw_byte_q, rmw_byte_d;
  logic [1:0]        rmw_lane_q, rmw_lane_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] req_idx;
  logic [1:0]        req_lane;
  logic [DATA_W-1:0] req_word;
  logic [7:0]        req_byte;
  logic [DATA_W-1:0] rmw_word;
  logic [DATA_W-1:0] merged_word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_widx;
  logic [DATA_W-1:0] mem_wdata;

  // Upper address bits are deliberately dropped so accesses wrap modulo the array.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[31:ADDR_W+2];

  assign req_idx  = req_addr_i[ADDR_W+1:2];
  assign req_lane = req_addr_i[1:0];
  assign req_word = mem[req_idx];
  assign req_byte = req_word[8*req_lane +: 8];
  assign rmw_word = mem[rmw_idx_q];

  always_comb begin
    merged_word = rmw_word;
    merged_word[8*rmw_lane_q +: 8] = rmw_byte_q;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    rmw_idx_d  = rmw_idx_q;
    rmw_byte_d = rmw_byte_q;
    rmw_lane_d = rmw_lane_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    valid_d    = 1'b0;
    mem_we     = 1'b0;
    mem_widx   = req_idx;
    mem_wdata  = req_wdata_i;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_is_store_i && req_is_byte_i) begin
            rmw_idx_d  = req_idx;
            rmw_byte_d = req_wdata_i[7:0];
            rmw_lane_d = req_lane;
            state_d    = RMW;
          end else begin
            // Misaligned word ops still proceed on the aligned word; only the flag reports it.
            err_d   = !req_is_byte_i && (req_lane != 2'b00);
            valid_d = 1'b1;
            state_d = RESP;
            if (req_is_store_i) begin
              mem_we  = 1'b1;
              rdata_d = '0;
            end else if (req_is_byte_i) begin
              rdata_d = {{(DATA_W-8){1'b0}}, req_byte};
            end else begin
              rdata_d = req_word;
            end
          end
        end
      end
      RMW: begin
        // The merged word lands only on the edge leaving RMW, so a reset here leaves memory intact.
        mem_we    = 1'b1;
        mem_widx  = rmw_idx_q;
        mem_wdata = merged_word;
        rdata_d   = '0;
        err_d     = 1'b0;
        valid_d   = 1'b1;
        state_d   = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      rmw_idx_q  <= '0;
      rmw_byte_q <= '0;
      rmw_lane_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rmw_idx_q  <= rmw_idx_d;
      rmw_byte_q <= rmw_byte_d;
      rmw_lane_q <= rmw_lane_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
    end
  end

  // NOTE: the array has no reset so it maps onto plain RAM; contents survive n_reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a transaction-level memory model feeds a
// queue of expected responses that a per-cycle compare process checks.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_is_store_i = 1'b0;
  logic        req_is_byte_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  dmem_responder #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_is_store_i (req_is_store_i),
    .req_is_byte_i  (req_is_byte_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_rdata = '0;
  logic [31:0] last_resp = '0;
  logic        last_err  = 1'b0;
  logic [31:0] model_mem [int];
  bit          chk_en = 1'b0;
  bit          exp_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model at transaction level: word index from addr[11:2], byte lanes by shift/mask.
  task automatic model_access(input bit st, input bit by, input logic [31:0] a,
                              input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int          idx;
    int          sh;
    logic [31:0] w;
    idx = int'(a[11:2]);
    sh  = 8 * int'(a[1:0]);
    err = !by && (a[1:0] != 2'b00);
    w   = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
    rd  = 32'h0;
    if (st) begin
      if (by) w = (w & ~(32'hFF << sh)) | ({24'h0, wd[7:0]} << sh);
      else    w = wd;
      model_mem[idx] = w;
    end else begin
      rd = by ? ((w >> sh) & 32'hFF) : w;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && n_reset) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
      exp_valid = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check("req_ready", {31'b0, req_ready_o}, {31'b0, exp_q.size() == 0});
      check("resp_valid", {31'b0, resp_valid_o}, {31'b0, exp_valid});
      if (exp_valid) begin
        check("resp_rdata", resp_rdata_o, exp_q[0].rdata);
        check("resp_err", {31'b0, resp_err_o}, {31'b0, exp_q[0].err});
        exp_rdata = exp_q[0].rdata;
        last_resp = resp_rdata_o;
        last_err  = resp_err_o;
        void'(exp_q.pop_front());
      end else begin
        check("rdata_hold", resp_rdata_o, exp_rdata);
      end
    end
  end

  task automatic do_req(input bit st, input bit by, input logic [31:0] a,
                        input logic [31:0] wd, input bit keep);
    logic [31:0] rd;
    logic        err;
    bit          accepted;
    accepted = 1'b0;
    @(negedge clk);
    req_valid_i    = 1'b1;
    req_is_store_i = st;
    req_is_byte_i  = by;
    req_addr_i     = a;
    req_wdata_i    = wd;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (req_ready_o) begin
        model_access(st, by, a, wd, rd, err);
        exp_q.push_back('{due: cyc + 1 + ((st && by) ? 1 : 0), rdata: rd, err: err});
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!accepted) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid_i = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      if (!keep) req_valid_i = 1'b0;
    end
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!done) check("resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] saved_word;

  initial begin
    #3;
    check("rst_valid", {31'b0, resp_valid_o}, 32'd0);
    check("rst_rdata", resp_rdata_o, 32'd0);
    check("rst_err", {31'b0, resp_err_o}, 32'd0);
    check("rst_ready", {31'b0, req_ready_o}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    n_reset = 1'b1;
    chk_en  = 1'b1;

    // Word round trip
    do_req(1, 0, 32'h10, 32'hDEADBEEF, 0);
    do_req(0, 0, 32'h10, 32'h0, 0);
    wait_done();
    check("lw_roundtrip", last_resp, 32'hDEADBEEF);
    check("lw_roundtrip_err", {31'b0, last_err}, 32'd0);

    // Byte merge through RMW
    do_req(1, 0, 32'h20, 32'h11223344, 0);
    do_req(1, 1, 32'h22, 32'h000000AB, 0);
    do_req(0, 0, 32'h20, 32'h0, 0);
    wait_done();
    check("sb_merge", last_resp, 32'h11AB3344);
    check("sb_merge_model", model_mem[8], 32'h11AB3344);

    // LBU zero-extension on every lane
    do_req(1, 0, 32'h30, 32'h80FF7F01, 0);
    do_req(0, 1, 32'h30, 32'h0, 0); wait_done(); check("lbu_lane0", last_resp, 32'h01);
    do_req(0, 1, 32'h31, 32'h0, 0); wait_done(); check("lbu_lane1", last_resp, 32'h7F);
    do_req(0, 1, 32'h32, 32'h0, 0); wait_done(); check("lbu_lane2", last_resp, 32'hFF);
    do_req(0, 1, 32'h33, 32'h0, 0); wait_done(); check("lbu_lane3", last_resp, 32'h80);

    // Misaligned word ops and address wrap
    do_req(0, 0, 32'h12, 32'h0, 0);
    wait_done();
    check("lw_misaligned", last_resp, 32'hDEADBEEF);
    check("lw_misaligned_err", {31'b0, last_err}, 32'd1);
    do_req(1, 0, 32'h17, 32'h12345678, 0);
    wait_done();
    check("sw_misaligned_err", {31'b0, last_err}, 32'd1);
    do_req(0, 1, 32'h14, 32'h0, 0);
    wait_done();
    check("lbu_after_misaligned_sw", last_resp, 32'h78);
    check("lbu_err", {31'b0, last_err}, 32'd0);
    do_req(1, 0, 32'h1010, 32'hCAFEF00D, 0);
    do_req(0, 0, 32'h10, 32'h0, 0);
    wait_done();
    check("wrap_alias", last_resp, 32'hCAFEF00D);

    // Back-to-back with req_valid_i held high throughout
    do_req(1, 0, 32'h40, 32'h00000001, 1);
    do_req(0, 0, 32'h40, 32'h0, 1);
    do_req(1, 1, 32'h41, 32'h00000099, 1);
    do_req(0, 0, 32'h40, 32'h0, 0);
    wait_done();
    check("burst_result", last_resp, 32'h00009901);

    // Reset in the middle of an RMW sequence
    do_req(1, 0, 32'h20, 32'h11223344, 0);
    do_req(0, 0, 32'h10, 32'h0, 0);
    wait_done();
    saved_word = model_mem[8];
    do_req(1, 1, 32'h20, 32'h00000055, 0);
    #1;
    n_reset = 1'b0;
    #1;
    check("rmw_rst_valid", {31'b0, resp_valid_o}, 32'd0);
    check("rmw_rst_rdata", resp_rdata_o, 32'd0);
    check("rmw_rst_err", {31'b0, resp_err_o}, 32'd0);
    check("rmw_rst_ready", {31'b0, req_ready_o}, 32'd1);
    exp_q.delete();
    exp_rdata      = '0;
    model_mem[8]   = saved_word;
    repeat (2) @(negedge clk);
    #2;
    n_reset = 1'b1;
    do_req(0, 0, 32'h20, 32'h0, 0);
    wait_done();
    check("rmw_rst_word_intact", last_resp, 32'h11223344);

    repeat (3) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
